mips_controller: RTL and testbench

Multi-cycle control unit that drives the control inputs of the 32-bit MIPS `data_path` from the fetched instruction's opcode/funct and the ALU `ZERO` flag. It sequences every instruction through FETCH/DECODE/EXEC/MEM/WB states. Write enables and the PC update strobe are confined to each instruction's final state. It also counts retired instructions and flags unsupported opcodes.

---
 rtl/mips_controller_if.sv | 39 +++
 rtl/mips_controller.sv | 251 +++++++++++++++++++++++++
 tb/tb_mips_controller.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_controller_if.sv
// Control bus between the multi-cycle MIPS controller and its datapath.
// The controller side drives the mux selects and enables and reads back
// the fetched instruction fields and the ALU zero flag.
interface mips_controller_if;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        reg_dst;
    logic        jal_reg;
    logic        pc_to_reg;
    logic        alu_src;
    logic        mem_to_reg;
    logic        jump_sel;
    logic        pc_jump;
    logic        pc_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  alu_cntrl;
    logic        pc_write;
    logic        illegal;
    logic [15:0] retired;

    // Controller side
    modport master (
        input  opcode, funct, zero,
        output reg_dst, jal_reg, pc_to_reg, alu_src, mem_to_reg,
               jump_sel, pc_jump, pc_src, reg_write, mem_read, mem_write,
               alu_cntrl, pc_write, illegal, retired
    );

    // Datapath side
    modport slave (
        output opcode, funct, zero,
        input  reg_dst, jal_reg, pc_to_reg, alu_src, mem_to_reg,
               jump_sel, pc_jump, pc_src, reg_write, mem_read, mem_write,
               alu_cntrl, pc_write, illegal, retired
    );
endinterface

// File: rtl/mips_controller.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencer that
// decodes a latched copy of opcode/funct, confines all write enables and
// the PC strobe to each instruction's final state, counts retired
// instructions and flags unsupported encodings.
module mips_controller (
    input  logic              clk,
    input  logic              rst,
    mips_controller_if.master bus
);

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
    } state_t;

    typedef enum logic [3:0] {
        C_ADD, C_SUB, C_AND, C_OR, C_SLT, C_JR,
        C_ADDI, C_SLTI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ILLEGAL
    } iclass_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [5:0]  r_opcode;
    logic [5:0]  r_funct;
    logic [15:0] r_retired;
    iclass_t     w_class;
    logic        w_rtype_alu;

    logic        w_reg_dst, w_jal_reg, w_pc_to_reg, w_alu_src, w_mem_to_reg;
    logic        w_jump_sel, w_pc_jump, w_pc_src, w_reg_write;
    logic        w_mem_read, w_mem_write, w_pc_write, w_illegal;
    logic [2:0]  w_alu_cntrl;

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture the instruction fields on the cycle that leaves FETCH
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_opcode <= '0;
            r_funct  <= '0;
        end else if (r_state == S_FETCH) begin
            r_opcode <= bus.opcode;
            r_funct  <= bus.funct;
        end
    end

    // Retired-instruction counter, advanced by each PC strobe
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_retired <= '0;
        end else if (w_pc_write) begin
            r_retired <= r_retired + 16'd1;
        end
    end

    // Classify the latched instruction
    // NOTE: every always_comb output gets a default first so no path
    // leaves a value unassigned and infers a latch.
    always_comb begin
        w_class = C_ILLEGAL;
        case (r_opcode)
            OP_RTYPE: begin
                case (r_funct)
                    FN_ADD:  w_class = C_ADD;
                    FN_SUB:  w_class = C_SUB;
                    FN_AND:  w_class = C_AND;
                    FN_OR:   w_class = C_OR;
                    FN_SLT:  w_class = C_SLT;
                    FN_JR:   w_class = C_JR;
                    default: w_class = C_ILLEGAL;
                endcase
            end
            OP_LW:   w_class = C_LW;
            OP_SW:   w_class = C_SW;
            OP_BEQ:  w_class = C_BEQ;
            OP_ADDI: w_class = C_ADDI;
            OP_SLTI: w_class = C_SLTI;
            OP_J:    w_class = C_J;
            OP_JAL:  w_class = C_JAL;
            default: w_class = C_ILLEGAL;
        endcase
    end

    assign w_rtype_alu = (w_class == C_ADD) || (w_class == C_SUB) ||
                         (w_class == C_AND) || (w_class == C_OR)  ||
                         (w_class == C_SLT);

    // Next-state sequencing
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: w_next_state = S_EXEC;
            S_EXEC: begin
                if (w_rtype_alu || w_class == C_ADDI || w_class == C_SLTI) begin
                    w_next_state = S_WB;
                end else if (w_class == C_LW || w_class == C_SW) begin
                    w_next_state = S_MEM;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_MEM:   w_next_state = (w_class == C_LW) ? S_WB : S_FETCH;
            S_WB:    w_next_state = S_FETCH;
            default: w_next_state = S_FETCH;
        endcase
    end

    // Control outputs from state and latched fields; all forced low in reset
    always_comb begin
        w_reg_dst    = 1'b0;
        w_jal_reg    = 1'b0;
        w_pc_to_reg  = 1'b0;
        w_alu_src    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_jump_sel   = 1'b0;
        w_pc_jump    = 1'b0;
        w_pc_src     = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_alu_cntrl  = ALU_ADD;
        w_pc_write   = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            S_EXEC: begin
                case (w_class)
                    C_ADD:  w_alu_cntrl = ALU_ADD;
                    C_SUB:  w_alu_cntrl = ALU_SUB;
                    C_AND:  w_alu_cntrl = ALU_AND;
                    C_OR:   w_alu_cntrl = ALU_OR;
                    C_SLT:  w_alu_cntrl = ALU_SLT;
                    C_ADDI: w_alu_src   = 1'b1;
                    C_SLTI: begin
                        w_alu_cntrl = ALU_SLT;
                        w_alu_src   = 1'b1;
                    end
                    C_LW, C_SW: w_alu_src = 1'b1;
                    C_BEQ: begin
                        w_alu_cntrl = ALU_SUB;
                        w_pc_src    = bus.zero;
                        w_pc_write  = 1'b1;
                    end
                    C_J: begin
                        w_jump_sel = 1'b1;
                        w_pc_jump  = 1'b1;
                        w_pc_write = 1'b1;
                    end
                    C_JAL: begin
                        w_jump_sel  = 1'b1;
                        w_pc_jump   = 1'b1;
                        w_jal_reg   = 1'b1;
                        w_pc_to_reg = 1'b1;
                        w_reg_write = 1'b1;
                        w_pc_write  = 1'b1;
                    end
                    C_JR: begin
                        w_pc_jump  = 1'b1;
                        w_pc_write = 1'b1;
                    end
                    default: begin
                        w_illegal  = 1'b1;
                        w_pc_write = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                if (w_class == C_LW) begin
                    w_mem_read = 1'b1;
                end else begin
                    w_mem_write = 1'b1;
                    w_pc_write  = 1'b1;
                end
            end
            S_WB: begin
                w_reg_write = 1'b1;
                w_pc_write  = 1'b1;
                if (w_class == C_LW) begin
                    w_mem_read   = 1'b1;
                    w_mem_to_reg = 1'b1;
                end else begin
                    w_reg_dst = w_rtype_alu;
                end
            end
            default: ;
        endcase
        if (!rst) begin
            w_reg_dst    = 1'b0;
            w_jal_reg    = 1'b0;
            w_pc_to_reg  = 1'b0;
            w_alu_src    = 1'b0;
            w_mem_to_reg = 1'b0;
            w_jump_sel   = 1'b0;
            w_pc_jump    = 1'b0;
            w_pc_src     = 1'b0;
            w_reg_write  = 1'b0;
            w_mem_read   = 1'b0;
            w_mem_write  = 1'b0;
            w_alu_cntrl  = 3'b000;
            w_pc_write   = 1'b0;
            w_illegal    = 1'b0;
        end
    end

    assign bus.reg_dst    = w_reg_dst;
    assign bus.jal_reg    = w_jal_reg;
    assign bus.pc_to_reg  = w_pc_to_reg;
    assign bus.alu_src    = w_alu_src;
    assign bus.mem_to_reg = w_mem_to_reg;
    assign bus.jump_sel   = w_jump_sel;
    assign bus.pc_jump    = w_pc_jump;
    assign bus.pc_src     = w_pc_src;
    assign bus.reg_write  = w_reg_write;
    assign bus.mem_read   = w_mem_read;
    assign bus.mem_write  = w_mem_write;
    assign bus.alu_cntrl  = w_alu_cntrl;
    assign bus.pc_write   = w_pc_write;
    assign bus.illegal    = w_illegal;
    assign bus.retired    = r_retired;

endmodule

// File: tb/tb_mips_controller.sv
// Self-checking bench for mips_controller: a table of instructions with
// hand-written per-cycle control words feeds a scoreboard queue, plus
// hand-driven sequences for reset, mid-instruction reset and counter wrap.
module tb_mips_controller;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips_controller_if bus ();

    mips_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Control word layout, MSB first:
    // reg_dst jal_reg pc_to_reg alu_src mem_to_reg jump_sel pc_jump pc_src
    // reg_write mem_read mem_write alu_cntrl[2:0] pc_write illegal
    localparam logic [15:0] RD   = 16'h8000;
    localparam logic [15:0] JRG  = 16'h4000;
    localparam logic [15:0] P2R  = 16'h2000;
    localparam logic [15:0] AS   = 16'h1000;
    localparam logic [15:0] M2R  = 16'h0800;
    localparam logic [15:0] JS   = 16'h0400;
    localparam logic [15:0] PJ   = 16'h0200;
    localparam logic [15:0] PS   = 16'h0100;
    localparam logic [15:0] RW   = 16'h0080;
    localparam logic [15:0] MR   = 16'h0040;
    localparam logic [15:0] MW   = 16'h0020;
    localparam logic [15:0] PW   = 16'h0002;
    localparam logic [15:0] IL   = 16'h0001;
    localparam logic [15:0] AAND = 16'h0000;
    localparam logic [15:0] AOR  = 16'h0004;
    localparam logic [15:0] AADD = 16'h0008;
    localparam logic [15:0] ASUB = 16'h0018;
    localparam logic [15:0] ASLT = 16'h001C;
    localparam logic [15:0] I    = AADD;

    typedef struct {
        string            name;
        logic [5:0]       opcode;
        logic [5:0]       funct;
        logic             zero;
        bit               scramble;
        int               cpi;
        logic [0:4][15:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        int          cyc;
        logic [15:0] ctl;
        logic [15:0] ret;
    } exp_t;

    vec_t        tbl[$];
    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_ret = 16'd0;

    function automatic vec_t mk(string name, logic [5:0] op, logic [5:0] fn,
                                logic z, bit scr, int cpi,
                                logic [15:0] c0, logic [15:0] c1, logic [15:0] c2,
                                logic [15:0] c3, logic [15:0] c4);
        vec_t v;
        v.name     = name;
        v.opcode   = op;
        v.funct    = fn;
        v.zero     = z;
        v.scramble = scr;
        v.cpi      = cpi;
        v.exp      = {c0, c1, c2, c3, c4};
        return v;
    endfunction

    function automatic logic [15:0] sample();
        return {bus.reg_dst, bus.jal_reg, bus.pc_to_reg, bus.alu_src,
                bus.mem_to_reg, bus.jump_sel, bus.pc_jump, bus.pc_src,
                bus.reg_write, bus.mem_read, bus.mem_write, bus.alu_cntrl,
                bus.pc_write, bus.illegal};
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Push the expected words, then step the instruction through its cycles
    task automatic run_vec(vec_t v);
        exp_t e;
        bus.opcode = v.opcode;
        bus.funct  = v.funct;
        bus.zero   = v.zero;
        for (int c = 0; c < v.cpi; c++) begin
            e.name = v.name;
            e.cyc  = c + 1;
            e.ctl  = v.exp[c];
            e.ret  = exp_ret;
            sb_q.push_back(e);
            if ((v.exp[c] & PW) != 16'd0) exp_ret = exp_ret + 16'd1;
        end
        for (int c = 0; c < v.cpi; c++) begin
            @(negedge clk);
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s: scoreboard empty at cycle %0d", v.name, c + 1);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("%s c%0d ctl", e.name, e.cyc), sample(), e.ctl);
                check($sformatf("%s c%0d retired", e.name, e.cyc), bus.retired, e.ret);
            end
            @(posedge clk);
            #1;
            if (c == 0 && v.scramble) begin
                bus.opcode = v.opcode ^ 6'h3F;
                bus.funct  = v.funct ^ 6'h3F;
            end
        end
    endtask

    initial begin
        vec_t v_lw, v_j, v_addi, v_beq;

        v_lw   = mk("lw",   6'b100011, 6'b000000, 1'b0, 1'b0, 5,
                    I, I, AS | AADD, MR | AADD, MR | M2R | RW | PW | AADD);
        v_j    = mk("j",    6'b000010, 6'b000000, 1'b0, 1'b0, 3,
                    I, I, JS | PJ | PW | AADD, 16'h0, 16'h0);
        v_addi = mk("addi", 6'b001000, 6'b000000, 1'b0, 1'b0, 4,
                    I, I, AS | AADD, RW | PW | AADD, 16'h0);
        v_beq  = mk("beq_z1", 6'b000100, 6'b000000, 1'b1, 1'b0, 3,
                    I, I, ASUB | PS | PW, 16'h0, 16'h0);

        tbl.push_back(v_lw);
        tbl.push_back(mk("sub_latched", 6'b000000, 6'b100010, 1'b0, 1'b1, 4,
                         I, I, ASUB, RD | RW | PW | AADD, 16'h0));
        tbl.push_back(mk("add", 6'b000000, 6'b100000, 1'b0, 1'b0, 4,
                         I, I, AADD, RD | RW | PW | AADD, 16'h0));
        tbl.push_back(mk("and", 6'b000000, 6'b100100, 1'b0, 1'b0, 4,
                         I, I, AAND, RD | RW | PW | AADD, 16'h0));
        tbl.push_back(mk("or", 6'b000000, 6'b100101, 1'b0, 1'b0, 4,
                         I, I, AOR, RD | RW | PW | AADD, 16'h0));
        tbl.push_back(mk("slt", 6'b000000, 6'b101010, 1'b0, 1'b0, 4,
                         I, I, ASLT, RD | RW | PW | AADD, 16'h0));
        tbl.push_back(v_addi);
        tbl.push_back(mk("slti", 6'b001010, 6'b000000, 1'b0, 1'b0, 4,
                         I, I, AS | ASLT, RW | PW | AADD, 16'h0));
        tbl.push_back(v_beq);
        tbl.push_back(mk("beq_z0", 6'b000100, 6'b000000, 1'b0, 1'b0, 3,
                         I, I, ASUB | PW, 16'h0, 16'h0));
        tbl.push_back(v_j);
        tbl.push_back(mk("jal", 6'b000011, 6'b000000, 1'b0, 1'b0, 3,
                         I, I, JS | PJ | JRG | P2R | RW | PW | AADD, 16'h0, 16'h0));
        tbl.push_back(mk("jr", 6'b000000, 6'b001000, 1'b0, 1'b0, 3,
                         I, I, PJ | PW | AADD, 16'h0, 16'h0));
        tbl.push_back(mk("sw", 6'b101011, 6'b000000, 1'b0, 1'b0, 4,
                         I, I, AS | AADD, MW | PW | AADD, 16'h0));
        tbl.push_back(v_lw);
        tbl.push_back(mk("illegal_op", 6'b111111, 6'b000000, 1'b0, 1'b0, 3,
                         I, I, IL | PW | AADD, 16'h0, 16'h0));
        tbl.push_back(mk("illegal_fn", 6'b000000, 6'b111111, 1'b0, 1'b1, 3,
                         I, I, IL | PW | AADD, 16'h0, 16'h0));
        tbl.push_back(mk("sw_latched", 6'b101011, 6'b000000, 1'b0, 1'b1, 4,
                         I, I, AS | AADD, MW | PW | AADD, 16'h0));

        // Reset held for two cycles with a lw on the bus
        rst        = 1'b0;
        bus.opcode = 6'b100011;
        bus.funct  = 6'b000000;
        bus.zero   = 1'b0;
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("reset c%0d ctl", c), sample(), 16'h0000);
            check($sformatf("reset c%0d retired", c), bus.retired, 16'h0000);
            @(posedge clk);
        end
        #1;
        rst = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            run_vec(tbl[k]);
        end

        // Reset during the MEM cycle of a lw
        bus.opcode = v_lw.opcode;
        bus.funct  = v_lw.funct;
        bus.zero   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("lw_rst c%0d ctl", c + 1), sample(), v_lw.exp[c]);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(negedge clk);
        check("lw_rst mem ctl", sample(), 16'h0000);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        exp_ret = 16'd0;
        run_vec(v_j);

        // Preload the counter to its maximum and retire across the wrap
        force dut.r_retired = 16'hFFFF;
        #1;
        release dut.r_retired;
        exp_ret = 16'hFFFF;
        run_vec(v_addi);
        run_vec(v_beq);

        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left, expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
